load_store_unit: RTL

MEM-stage load/store unit sitting directly upstream of `data_memory`: accepts one load/store request at a time from the pipeline and drives the byte-addressed, big-endian, 16-bit-word data memory. It also returns formatted load data to the pipeline. It adds byte and halfword accesses with sign/zero extension, and implements byte stores as read-modify-write on the aligned word. It always issues word-aligned memory addresses, and it flags misaligned halfword accesses instead of issuing them.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage load/store unit in front of a byte-addressed, big-endian,
//   16-bit-word data memory. It accepts one request at a time. Halfword
//   loads and stores pass straight through. Byte loads select a lane and
//   sign- or zero-extend it. Byte stores are done as read-modify-write on
//   the aligned word. Misaligned halfword accesses are answered with an
//   error and never reach memory.
//
// Ports
//   clk, rst (async, active-low)
//   req_valid/req_ready : request handshake
//   req_we, req_size, req_signed, req_addr, req_wdata : request fields
//   resp_valid, resp_data, resp_err : one-cycle completion pulse
//   mem_rd_en, mem_wr_en, mem_addr, mem_wr_data : to data_memory
//   mem_read_data : from data_memory, valid the cycle after mem_rd_en
module load_store_unit #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_size,
  input  logic                 req_signed,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_data,
  output logic                 resp_err,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wr_data,
  input  logic [BUS_WIDTH-1:0] mem_read_data
);

  localparam int BW = BUS_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RMW_WR  = 3'd2,
    ST_DONE = 3'd3,
    ERR     = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] lat_addr;
  logic          lat_lane;
  logic          lat_size;
  logic          lat_signed;
  logic [7:0]    lat_byte;
  logic          hs;
  logic          misaligned;

  function automatic logic [BW-1:0] word_addr(input logic [BW-1:0] a);
    return {a[BW-1:1], 1'b0};
  endfunction

  // Big-endian: lane 0 (even byte address) is the upper byte of the word.
  function automatic logic [7:0] pick_lane(input logic [BW-1:0] w, input logic lane);
    return lane ? w[7:0] : w[BW-1 -: 8];
  endfunction

  function automatic logic [BW-1:0] extend_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]    b_s;
    logic signed [BW-1:0] b_ext;
    b_s   = b;
    b_ext = b_s;
    return sgn ? b_ext : {{(BW-8){1'b0}}, b};
  endfunction

  function automatic logic [BW-1:0] merge_byte(input logic [BW-1:0] w, input logic lane,
                                               input logic [7:0] b);
    logic [BW-1:0] m;
    m = w;
    if (lane) m[7:0] = b;
    else      m[BW-1 -: 8] = b;
    return m;
  endfunction

  assign hs         = rst && (state == IDLE) && req_valid;
  assign misaligned = req_size && req_addr[0];

  // Request stage: latch the fields needed by the following states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_lane   <= 1'b0;
      lat_size   <= 1'b0;
      lat_signed <= 1'b0;
      lat_byte   <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        lat_addr   <= word_addr(req_addr);
        lat_lane   <= req_addr[0];
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_byte   <= req_wdata[7:0];
      end
    end
  end

  // Memory/response stage: outputs decoded from state and latched request
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = '0;
    resp_err    = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      IDLE: begin
        req_ready = rst;
        if (hs) begin
          if (misaligned) begin
            state_nxt = ERR;
          end else if (!req_we) begin
            mem_rd_en = 1'b1;
            mem_addr  = word_addr(req_addr);
            state_nxt = LOAD;
          end else if (req_size) begin
            mem_wr_en   = 1'b1;
            mem_addr    = word_addr(req_addr);
            mem_wr_data = req_wdata;
            state_nxt   = ST_DONE;
          end else begin
            mem_rd_en = 1'b1;
            mem_addr  = word_addr(req_addr);
            state_nxt = RMW_WR;
          end
        end
      end
      LOAD: begin
        resp_valid = 1'b1;
        resp_data  = lat_size ? mem_read_data
                              : extend_byte(pick_lane(mem_read_data, lat_lane), lat_signed);
        state_nxt  = IDLE;
      end
      RMW_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = lat_addr;
        mem_wr_data = merge_byte(mem_read_data, lat_lane, lat_byte);
        state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
